// File: rtl/fp_multiplier_pipelined.sv
// Three-stage pipelined IEEE-754 multiplier: unpack/classify, significand multiply,
// normalize/round-to-nearest-even/pack, with valid/ready handshake and status flags.
module fp_multiplier_pipelined #(
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23,
    parameter int D_WIDTH = 1 + E_WIDTH + M_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] floating1_in,
    input  logic [D_WIDTH-1:0] floating2_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] floating_multiplication_out,
    output logic               flag_overflow,
    output logic               flag_underflow,
    output logic               flag_invalid,
    output logic               flag_inexact
);

    localparam int P_WIDTH = 2 * M_WIDTH + 2;
    localparam int S_WIDTH = M_WIDTH + 1;
    localparam int X_WIDTH = E_WIDTH + 2;

    localparam logic signed [X_WIDTH-1:0] BIAS      = {3'b000, {(E_WIDTH-1){1'b1}}};
    localparam logic signed [X_WIDTH-1:0] EXP_LIMIT = {2'b00, {E_WIDTH{1'b1}}};
    localparam logic signed [X_WIDTH-1:0] EXP_ZERO  = '0;
    localparam logic [E_WIDTH-1:0]        EXP_ONES  = '1;
    localparam logic [D_WIDTH-1:0]        QNAN      = {1'b0, EXP_ONES, 1'b1, {(M_WIDTH-1){1'b0}}};

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    logic               sign_a, sign_b;
    logic [E_WIDTH-1:0] exp_a, exp_b;
    logic [M_WIDTH-1:0] frac_a, frac_b;
    logic               zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic signed [X_WIDTH-1:0] esum;

    assign sign_a = floating1_in[D_WIDTH-1];
    assign sign_b = floating2_in[D_WIDTH-1];
    assign exp_a  = floating1_in[D_WIDTH-2 -: E_WIDTH];
    assign exp_b  = floating2_in[D_WIDTH-2 -: E_WIDTH];
    assign frac_a = floating1_in[M_WIDTH-1:0];
    assign frac_b = floating2_in[M_WIDTH-1:0];

    // Denormal operands are flushed to zero, so exp==0 alone marks a zero.
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
    assign inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
    assign nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
    assign nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);
    assign esum   = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;

    logic                      s1_valid, s1_sign, s1_invalid, s1_inf, s1_zero;
    logic signed [X_WIDTH-1:0] s1_esum;
    logic [S_WIDTH-1:0]        s1_sig_a, s1_sig_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_invalid <= 1'b0;
            s1_inf     <= 1'b0;
            s1_zero    <= 1'b0;
            s1_esum    <= '0;
            s1_sig_a   <= '0;
            s1_sig_b   <= '0;
        end else if (!stall) begin
            s1_valid   <= in_valid;
            s1_sign    <= sign_a ^ sign_b;
            s1_invalid <= nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);
            s1_inf     <= inf_a | inf_b;
            s1_zero    <= zero_a | zero_b;
            s1_esum    <= esum;
            s1_sig_a   <= {1'b1, frac_a};
            s1_sig_b   <= {1'b1, frac_b};
        end
    end

    logic                      s2_valid, s2_sign, s2_invalid, s2_inf, s2_zero;
    logic signed [X_WIDTH-1:0] s2_esum;
    logic [P_WIDTH-1:0]        s2_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_invalid <= 1'b0;
            s2_inf     <= 1'b0;
            s2_zero    <= 1'b0;
            s2_esum    <= '0;
            s2_prod    <= '0;
        end else if (!stall) begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_invalid <= s1_invalid;
            s2_inf     <= s1_inf;
            s2_zero    <= s1_zero;
            s2_esum    <= s1_esum;
            s2_prod    <= {{S_WIDTH{1'b0}}, s1_sig_a} * {{S_WIDTH{1'b0}}, s1_sig_b};
        end
    end

    logic [P_WIDTH-1:0]        p_norm;
    logic [M_WIDTH-1:0]        frac_t;
    logic [M_WIDTH:0]          frac_sum;
    logic                      guard, sticky, round_up;
    logic signed [X_WIDTH-1:0] exp_norm, exp_rnd;
    logic [D_WIDTH-1:0]        res_d;
    logic                      ovf_d, unf_d, inv_d, inx_d;

    // The product of two [1,2) significands lies in [1,4): at most one normalizing shift.
    always_comb begin
        p_norm   = s2_prod[P_WIDTH-1] ? s2_prod : (s2_prod << 1);
        frac_t   = p_norm[P_WIDTH-2 -: M_WIDTH];
        guard    = p_norm[M_WIDTH];
        sticky   = |p_norm[M_WIDTH-1:0];
        exp_norm = s2_esum + $signed({{(X_WIDTH-1){1'b0}}, s2_prod[P_WIDTH-1]});
        round_up = guard & (sticky | frac_t[0]);
        frac_sum = {1'b0, frac_t} + {{M_WIDTH{1'b0}}, round_up};
        exp_rnd  = exp_norm + $signed({{(X_WIDTH-1){1'b0}}, frac_sum[M_WIDTH]});
        res_d    = {s2_sign, exp_rnd[E_WIDTH-1:0], frac_sum[M_WIDTH-1:0]};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inv_d    = 1'b0;
        inx_d    = guard | sticky;
        if (s2_invalid) begin
            res_d = QNAN;
            inv_d = 1'b1;
            inx_d = 1'b0;
        end else if (s2_inf) begin
            res_d = {s2_sign, EXP_ONES, {M_WIDTH{1'b0}}};
            inx_d = 1'b0;
        end else if (s2_zero) begin
            res_d = {s2_sign, {(D_WIDTH-1){1'b0}}};
            inx_d = 1'b0;
        end else if (exp_rnd >= EXP_LIMIT) begin
            res_d = {s2_sign, EXP_ONES, {M_WIDTH{1'b0}}};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
            res_d = {s2_sign, {(D_WIDTH-1){1'b0}}};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid                   <= 1'b0;
            floating_multiplication_out <= '0;
            flag_overflow               <= 1'b0;
            flag_underflow              <= 1'b0;
            flag_invalid                <= 1'b0;
            flag_inexact                <= 1'b0;
        end else if (!stall) begin
            out_valid                   <= s2_valid;
            floating_multiplication_out <= res_d;
            flag_overflow               <= ovf_d;
            flag_underflow              <= unf_d;
            flag_invalid                <= inv_d;
            flag_inexact                <= inx_d;
        end
    end

endmodule

// File: tb/tb_fp_multiplier_pipelined.sv
// Scoreboard bench for fp_multiplier_pipelined: directed vectors, backpressure,
// mid-flight reset and randomized operands against an integer-arithmetic reference.
module tb_fp_multiplier_pipelined;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          issue;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] floating1_in, floating2_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] floating_multiplication_out;
    logic        flag_overflow, flag_underflow, flag_invalid, flag_inexact;

    fp_multiplier_pipelined dut (
        .clk                         (clk),
        .rst                         (rst),
        .in_valid                    (in_valid),
        .in_ready                    (in_ready),
        .floating1_in                (floating1_in),
        .floating2_in                (floating2_in),
        .out_valid                   (out_valid),
        .out_ready                   (out_ready),
        .floating_multiplication_out (floating_multiplication_out),
        .flag_overflow               (flag_overflow),
        .flag_underflow              (flag_underflow),
        .flag_invalid                (flag_invalid),
        .flag_inexact                (flag_inexact)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_popped = 0;
    int   cyc = 0;
    int   bp_mode = 0;
    bit   ready_cmd = 1'b1;

    logic [3:0] flags;
    assign flags = {flag_overflow, flag_underflow, flag_invalid, flag_inexact};

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Exact product as integers, rounded by quotient/remainder against the halfway point.
    function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        int              ea, eb, len, sh, be;
        longint unsigned ma, mb, prod, q, rem, half;
        bit              sign, za, zb, ia, ib, na, nb;
        e.flg   = 4'b0000;
        e.issue = 0;
        e.lat   = 1'b0;
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        sign = a[31] ^ b[31];
        za   = (ea == 0);
        zb   = (eb == 0);
        ia   = (ea == 255) && (a[22:0] == 0);
        ib   = (eb == 255) && (b[22:0] == 0);
        na   = (ea == 255) && (a[22:0] != 0);
        nb   = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (ia && zb) || (za && ib)) begin
            e.res = 32'h7FC0_0000;
            e.flg = 4'b0010;
        end else if (ia || ib) begin
            e.res = {sign, 8'hFF, 23'd0};
        end else if (za || zb) begin
            e.res = {sign, 31'd0};
        end else begin
            ma   = (64'd1 << 23) | 64'(a[22:0]);
            mb   = (64'd1 << 23) | 64'(b[22:0]);
            prod = ma * mb;
            len  = 0;
            while ((prod >> len) != 0) len++;
            sh   = len - 24;
            q    = prod >> sh;
            rem  = prod - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                sh++;
            end
            be = ea + eb + sh - 150;
            if (be >= 255) begin
                e.res = {sign, 8'hFF, 23'd0};
                e.flg = 4'b1001;
            end else if (be <= 0) begin
                e.res = {sign, 31'd0};
                e.flg = 4'b0101;
            end else begin
                e.res = {sign, be[7:0], q[22:0]};
                e.flg = {3'b000, rem != 0};
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] randOperand();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0:       v[30:23] = 8'h00;
            1:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
            3:       v[30:23] = 8'($urandom_range(1, 20));
            4:       v[30:23] = 8'($urandom_range(235, 254));
            default: v[30:23] = 8'($urandom_range(90, 165));
        endcase
        return v;
    endfunction

    // Holds the operands until accepted; the expectation is queued at the accepting cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        bit accepted = 1'b0;
        int tries = 0;
        in_valid     = 1'b1;
        floating1_in = a;
        floating2_in = b;
        while (!accepted) begin
            @(negedge clk);
            accepted = in_ready;
            if (accepted) begin
                e.issue = cyc;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            tries++;
            if (!accepted && tries >= 200) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", tries);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_queue_left", 64'(sb.size()), 64'd0);
    endtask

    // Sole driver of out_ready: fixed level, random, or a 4-cycle stall on the first result.
    initial begin
        int  stall_cnt = 0;
        bit  stall_done = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_cnt == 0 && !stall_done && out_valid) begin
                        stall_cnt  = 4;
                        stall_done = 1'b1;
                    end
                    if (stall_cnt > 0) begin
                        out_ready = 1'b0;
                        stall_cnt--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = ready_cmd;
            endcase
            if (bp_mode != 2) stall_done = 1'b0;
        end
    end

    // Monitor: pops on every output transfer, and checks hold/back-pressure behaviour.
    initial begin
        bit          prev_stall = 1'b0;
        logic [31:0] prev_out = '0;
        logic [3:0]  prev_flags = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checkOutput("hold_valid", 64'(out_valid), 64'd1);
                    checkOutput("hold_data", 64'(floating_multiplication_out), 64'(prev_out));
                    checkOutput("hold_flags", 64'(flags), 64'(prev_flags));
                end
                if (out_valid && !out_ready)
                    checkOutput("in_ready_stall", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("[TB] FAIL spurious_result: got %08h with no pending operation, expected none",
                                 floating_multiplication_out);
                    end else begin
                        e = sb.pop_front();
                        n_popped++;
                        checkOutput("result", 64'(floating_multiplication_out), 64'(e.res));
                        checkOutput("flags_ovf_unf_inv_inx", 64'(flags), 64'(e.flg));
                        if (e.lat) checkOutput("latency", 64'(cyc - e.issue), 64'd3);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = floating_multiplication_out;
                prev_flags = flags;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] dir_a   [9] = '{32'h40400000, 32'hC0000000, 32'h3FC00000, 32'h3F800001, 32'h7F000000,
                                 32'h00800000, 32'h7F800000, 32'hFF800000, 32'h80000000};
    logic [31:0] dir_b   [9] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h7F000000,
                                 32'h00800000, 32'h00000000, 32'h40000000, 32'h3F800000};
    logic [31:0] dir_res [9] = '{32'h40C00000, 32'hC0C00000, 32'h40100000, 32'h3F800002, 32'h7F800000,
                                 32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h80000000};
    logic [3:0]  dir_flg [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1001,
                                 4'b0101, 4'b0010, 4'b0000, 4'b0000};

    initial begin
        exp_t e;
        int   popped_before;
        rst          = 1'b1;
        in_valid     = 1'b0;
        floating1_in = '0;
        floating2_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_data", 64'(floating_multiplication_out), 64'd0);
        checkOutput("reset_flags", 64'(flags), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed vectors");
        for (int i = 0; i < 9; i++) begin
            e.res = dir_res[i];
            e.flg = dir_flg[i];
            e.lat = 1'b1;
            e.issue = 0;
            applyStimulus(dir_a[i], dir_b[i], e);
            waitDrain(20);
        end

        $display("[TB] backpressure: 6 back-to-back ops, 4-cycle stall");
        popped_before = n_popped;
        bp_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = randOperand();
            b = randOperand();
            applyStimulus(a, b, refModel(a, b));
        end
        waitDrain(40);
        checkOutput("bp_result_count", 64'(n_popped - popped_before), 64'd6);
        bp_mode = 0;
        ready_cmd = 1'b1;

        $display("[TB] reset with operations in flight");
        ready_cmd = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a, b;
            a = randOperand();
            b = randOperand();
            applyStimulus(a, b, refModel(a, b));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_flags", 64'(flags), 64'd0);
        ready_cmd = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
        end

        $display("[TB] randomized operands with random backpressure");
        bp_mode = 1;
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a, b;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            a = randOperand();
            b = randOperand();
            applyStimulus(a, b, refModel(a, b));
        end
        bp_mode = 0;
        ready_cmd = 1'b1;
        waitDrain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
